quad_peak_finder: RTL and testbench

QUAD_PEAK_FINDER -- requirements
Module: quad_peak_finder

---
 rtl/quad_peak_finder.sv | 110 +++++++++++
 tb/tb_quad_peak_finder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_peak_finder.sv
// quad_peak_finder
// Collects a frame of N_SAMPLES (x, y) pairs from an upstream quadratic
// evaluator and reports the largest y with its x, the smallest y with its
// x, and the signed sum of all y. The result is held with a valid/ready
// handshake until downstream takes it, then kept on the outputs while idle.
module quad_peak_finder #(
    parameter  int WL        = 15,
    parameter  int N_SAMPLES = 16,
    localparam int SUMW      = WL + 9
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic signed [WL-1:0]   in_x,
    input  logic signed [WL:0]     in_y,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [WL:0]     max_y,
    output logic signed [WL-1:0]   max_x,
    output logic signed [WL:0]     min_y,
    output logic signed [WL-1:0]   min_x,
    output logic signed [SUMW-1:0] sum_y
);

    localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

    // Seeds chosen so the first accepted sample always wins both
    // comparisons, except when it sits exactly on the extreme itself.
    localparam logic signed [WL:0] Y_MOST_NEG = {1'b1, {WL{1'b0}}};
    localparam logic signed [WL:0] Y_MOST_POS = {1'b0, {WL{1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [SUMW-1:0] y_ext;

    assign y_ext = {{(SUMW - WL - 1){in_y[WL]}}, in_y};

    // Frame FSM with registered status and result outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            count     <= '0;
            max_y     <= '0;
            max_x     <= '0;
            min_y     <= '0;
            min_x     <= '0;
            sum_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                        count <= '0;
                        max_y <= Y_MOST_NEG;
                        min_y <= Y_MOST_POS;
                        max_x <= '0;
                        min_x <= '0;
                        sum_y <= '0;
                    end
                end

                COLLECT: begin
                    if (in_valid) begin
                        if (in_y > max_y) begin
                            max_y <= in_y;
                            max_x <= in_x;
                        end
                        if (in_y < min_y) begin
                            min_y <= in_y;
                            min_x <= in_x;
                        end
                        sum_y <= sum_y + $signed(y_ext);
                        count <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            state     <= HOLD;
                            res_valid <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_peak_finder.sv
// tb_quad_peak_finder
// Directed bench for quad_peak_finder with a four-sample frame: a table of
// frames with hand-computed results, plus hand-written sequences for
// ignored inputs and asynchronous reset in the middle of a frame.
module tb_quad_peak_finder;

    localparam int WL   = 15;
    localparam int NS   = 4;
    localparam int SUMW = WL + 9;
    localparam int NV   = 5;

    logic                   CLK;
    logic                   RST;
    logic                   start;
    logic                   in_valid;
    logic signed [WL-1:0]   in_x;
    logic signed [WL:0]     in_y;
    logic                   busy;
    logic                   res_valid;
    logic                   res_ready;
    logic signed [WL:0]     max_y;
    logic signed [WL-1:0]   max_x;
    logic signed [WL:0]     min_y;
    logic signed [WL-1:0]   min_x;
    logic signed [SUMW-1:0] sum_y;

    int testsRun    = 0;
    int testsFailed = 0;

    // Field order: y0..y3, x0..x3, maxy, maxx, miny, minx, sumy, gap, stall
    typedef struct packed {
        int y0; int y1; int y2; int y3;
        int x0; int x1; int x2; int x3;
        int maxy; int maxx; int miny; int minx; int sumy;
        int gap; int stall;
    } frame_t;

    frame_t frames [NV];

    quad_peak_finder #(.WL(WL), .N_SAMPLES(NS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .max_y     (max_y),
        .max_x     (max_x),
        .min_y     (min_y),
        .min_x     (min_x),
        .sum_y     (sum_y)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int sampleY(frame_t f, int i);
        case (i)
            0: return f.y0;
            1: return f.y1;
            2: return f.y2;
            default: return f.y3;
        endcase
    endfunction

    function automatic int sampleX(frame_t f, int i);
        case (i)
            0: return f.x0;
            1: return f.x1;
            2: return f.x2;
            default: return f.x3;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkResults(input string tag, input frame_t f);
        checkOutput({tag, " max_y"}, max_y, f.maxy);
        checkOutput({tag, " max_x"}, max_x, f.maxx);
        checkOutput({tag, " min_y"}, min_y, f.miny);
        checkOutput({tag, " min_x"}, min_x, f.minx);
        checkOutput({tag, " sum_y"}, sum_y, f.sumy);
    endtask

    task automatic driveSample(input frame_t f, input int i);
        int tx;
        int ty;
        tx = sampleX(f, i);
        ty = sampleY(f, i);
        in_valid = 1'b1;
        in_x     = tx[WL-1:0];
        in_y     = ty[WL:0];
    endtask

    // Runs one whole frame from IDLE: start, samples with gaps, stalled
    // hold, then handshake back to IDLE.
    task automatic applyStimulus(input string tag, input frame_t f);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, " busy after start"}, 32'(busy), 1);
        for (int i = 0; i < NS; i++) begin
            driveSample(f, i);
            tick();
            in_valid = 1'b0;
            if (i < NS - 1) begin
                checkOutput({tag, " res_valid early"}, 32'(res_valid), 0);
                repeat (f.gap) tick();
            end
        end
        checkOutput({tag, " res_valid latency"}, 32'(res_valid), 1);
        checkOutput({tag, " busy in hold"}, 32'(busy), 1);
        res_ready = 1'b0;
        for (int s = 0; s < f.stall; s++) begin
            tick();
            checkOutput({tag, " res_valid stalled"}, 32'(res_valid), 1);
            checkResults({tag, " stalled"}, f);
        end
        checkResults(tag, f);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput({tag, " res_valid after accept"}, 32'(res_valid), 0);
        checkOutput({tag, " busy after accept"}, 32'(busy), 0);
        checkResults({tag, " kept in idle"}, f);
    endtask

    // Main test sequence.
    initial begin
        frame_t f0;
        frame_t zero;

        frames[0] = '{-3, -4, -13, -30, 0, 1, 2, 3, -3, 0, -30, 3, -50, 0, 0};
        frames[1] = '{5, 5, -2, -2, 1, 2, 3, 4, 5, 1, -2, 3, 6, 0, 1};
        frames[2] = '{-3, -4, -13, -30, 0, 1, 2, 3, -3, 0, -30, 3, -50, 2, 3};
        frames[3] = '{-32768, 32767, 32767, 32767, 5, 6, 7, -8,
                      32767, 6, -32768, 5, 65533, 0, 0};
        frames[4] = '{10, -7, 20, -7, -1, -2, -3, -4, 20, -3, -7, -2, 16, 1, 0};
        zero = '0;
        f0   = frames[0];

        RST       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        res_ready = 1'b0;
        #3;
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset res_valid", 32'(res_valid), 0);
        checkResults("reset", zero);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick();

        for (int v = 0; v < NV; v++) begin
            applyStimulus($sformatf("frame%0d", v), frames[v]);
        end

        // in_valid in IDLE, then start together with in_valid.
        in_valid = 1'b1;
        in_x     = 15'sd9;
        in_y     = 16'sd1000;
        tick();
        checkOutput("idle in_valid busy", 32'(busy), 0);
        checkResults("idle in_valid", frames[NV-1]);
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("start+valid busy", 32'(busy), 1);
        for (int i = 0; i < NS; i++) begin
            driveSample(f0, i);
            start = 1'b1;
            tick();
            in_valid = 1'b0;
            if (i < NS - 1) begin
                tick();
                start = 1'b0;
            end
        end
        start     = 1'b1;
        in_valid  = 1'b1;
        in_x      = 15'sd7;
        in_y      = 16'sd30000;
        res_ready = 1'b0;
        tick();
        tick();
        checkOutput("hold ignores start", 32'(res_valid), 1);
        checkOutput("hold busy", 32'(busy), 1);
        checkResults("ignored inputs", f0);
        start     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        checkOutput("no start latched", 32'(busy), 0);
        checkOutput("no start res_valid", 32'(res_valid), 0);

        // Asynchronous reset between edges after two samples.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            driveSample(frames[3], i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async reset busy", 32'(busy), 0);
        checkOutput("async reset res_valid", 32'(res_valid), 0);
        checkResults("async reset", zero);
        RST = 1'b0;
        tick();
        driveSample(frames[3], 2);
        tick();
        in_valid = 1'b0;
        checkOutput("frame discarded busy", 32'(busy), 0);
        checkResults("frame discarded", zero);
        applyStimulus("after reset", f0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
